// File: rtl/dual_prio_encoder.sv
// Dual priority encoder: reports the highest and second-highest set request
// bits (bit N-1 wins), combinationally and as a one-cycle registered copy.
module dual_prio_encoder #(
  parameter int N = 12,
  localparam int W = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_first,
  output logic [W-1:0] o_second,
  output logic         o_first_valid,
  output logic         o_second_valid,
  output logic [W-1:0] o_first_q,
  output logic [W-1:0] o_second_q,
  output logic         o_first_valid_q,
  output logic         o_second_valid_q
);

  logic [W-1:0] w_first;
  logic [W-1:0] w_second;
  logic         w_first_valid;
  logic         w_second_valid;

  logic [W-1:0] r_first;
  logic [W-1:0] r_second;
  logic         r_first_valid;
  logic         r_second_valid;

  // Ascending scan: each set bit becomes the new leader and the old leader
  // drops to second place, so after the loop the top two indices remain.
  always_comb begin
    w_first        = '0;
    w_second       = '0;
    w_first_valid  = 1'b0;
    w_second_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_req[i]) begin
        w_second       = w_first;
        w_second_valid = w_first_valid;
        w_first        = W'(i);
        w_first_valid  = 1'b1;
      end
    end
  end

  // Output registers for pipelined arbitration; synchronous clear on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_first        <= '0;
      r_second       <= '0;
      r_first_valid  <= 1'b0;
      r_second_valid <= 1'b0;
    end else begin
      r_first        <= w_first;
      r_second       <= w_second;
      r_first_valid  <= w_first_valid;
      r_second_valid <= w_second_valid;
    end
  end

  assign o_first          = w_first;
  assign o_second         = w_second;
  assign o_first_valid    = w_first_valid;
  assign o_second_valid   = w_second_valid;
  assign o_first_q        = r_first;
  assign o_second_q       = r_second;
  assign o_first_valid_q  = r_first_valid;
  assign o_second_valid_q = r_second_valid;

endmodule

// File: tb/tb_dual_prio_encoder.sv
// Testbench for dual_prio_encoder: directed cases, exhaustive sweep of the
// combinational path, and randomized registered-path checks with reset.
module tb_dual_prio_encoder;

  localparam int N = 12;
  localparam int W = $clog2(N);

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [W-1:0] first, second, first_q, second_q;
  logic         first_valid, second_valid, first_valid_q, second_valid_q;

  int n_checks = 0;
  int n_pass   = 0;

  dual_prio_encoder #(.N(N)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req            (req),
    .o_first          (first),
    .o_second         (second),
    .o_first_valid    (first_valid),
    .o_second_valid   (second_valid),
    .o_first_q        (first_q),
    .o_second_q       (second_q),
    .o_first_valid_q  (first_valid_q),
    .o_second_valid_q (second_valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: list set indices from the top down; first two entries win.
  function automatic void model(input logic [N-1:0] r, output int f, output int s,
                                output int fv, output int sv);
    int idx[$];
    for (int i = N - 1; i >= 0; i--) if (r[i]) idx.push_back(i);
    fv = (idx.size() >= 1) ? 1 : 0;
    sv = (idx.size() >= 2) ? 1 : 0;
    f  = (idx.size() >= 1) ? idx[0] : 0;
    s  = (idx.size() >= 2) ? idx[1] : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (req=%h)", tag, obs, exp, req);
  endtask

  task automatic check_comb(input string tag);
    int f, s, fv, sv;
    model(req, f, s, fv, sv);
    check({tag, ".first"}, 32'(first), f);
    check({tag, ".second"}, 32'(second), s);
    check({tag, ".fv"}, 32'(first_valid), fv);
    check({tag, ".sv"}, 32'(second_valid), sv);
  endtask

  task automatic check_q(input string tag, input int f, input int s, input int fv, input int sv);
    check({tag, ".first_q"}, 32'(first_q), f);
    check({tag, ".second_q"}, 32'(second_q), s);
    check({tag, ".fv_q"}, 32'(first_valid_q), fv);
    check({tag, ".sv_q"}, 32'(second_valid_q), sv);
  endtask

  task automatic check_direct(input string tag, input int f, input int s, input int fv, input int sv);
    check({tag, ".first"}, 32'(first), f);
    check({tag, ".second"}, 32'(second), s);
    check({tag, ".fv"}, 32'(first_valid), fv);
    check({tag, ".sv"}, 32'(second_valid), sv);
  endtask

  initial begin
    int ef, es, efv, esv;
    logic rnd_rst;
    rst = 1'b1;
    req = '0;

    // Directed combinational corners
    #1; check_direct("zero", 0, 0, 0, 0);
    req = 12'h001; #1; check_direct("bit0", 0, 0, 1, 0);
    req = 12'h800; #1; check_direct("bit11", 11, 0, 1, 0);
    req = 12'h801; #1; check_direct("h801", 11, 0, 1, 1);
    req = 12'h0C0; #1; check_direct("h0C0", 7, 6, 1, 1);
    req = 12'hFFF; #1; check_direct("hFFF", 11, 10, 1, 1);

    // Exhaustive sweep, 2 ns per value
    for (int v = 0; v < (1 << N); v++) begin
      req = N'(v);
      #1; check_comb("sweep");
      #1;
    end

    // Registered path: reset hold, release, then a req change
    @(negedge clk); rst = 1'b1; req = 12'h0C0;
    @(posedge clk); @(posedge clk); #1;
    check_q("rst_hold", 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_q("release", 7, 6, 1, 1);
    @(negedge clk); req = 12'h024; #1;
    check_q("before_edge", 7, 6, 1, 1);
    check_direct("h024", 5, 2, 1, 1);
    @(posedge clk); #1;
    check_q("after_edge", 5, 2, 1, 1);

    // Randomized registered path with occasional reset
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      req     = N'($urandom);
      rnd_rst = ($urandom_range(0, 9) == 0);
      rst     = rnd_rst;
      #1; check_comb("rand_comb");
      model(req, ef, es, efv, esv);
      @(posedge clk); #1;
      if (rnd_rst) check_q("rand_rst", 0, 0, 0, 0);
      else         check_q("rand_q", ef, es, efv, esv);
    end

    // Reset mid-operation: registers clear, combinational path unaffected
    @(negedge clk); rst = 1'b0; req = 12'hFFF;
    @(posedge clk); #1;
    check_q("pre_mid", 11, 10, 1, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_q("mid_rst", 0, 0, 0, 0);
    check_direct("mid_comb", 11, 10, 1, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_q("post_mid", 11, 10, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_prio_encoder.md
Name: dual_prio_encoder

Overview:
Combinational dual priority encoder over an N-bit request vector. It reports the index of the highest-priority asserted request and of the second-highest. Bit N-1 has the highest priority; bit 0 has the lowest. A registered copy of the results, with valid flags, is also provided for downstream pipelined arbitration logic.

Parameters:
N, 12, width of request vector; legal range N >= 2.
W, $clog2(N) (derived localparam, not overridable), width of index outputs; W=4 for N=12.

Ports:
clk  input  1  system clock; all registers update on its rising edge.
rst  input  1  synchronous, active-high reset.
req  input  N  request vector; bit i set means requester i is active.
first  output  W  index of highest set bit of req (combinational).
second  output  W  index of second-highest set bit of req (combinational).
first_valid  output  1  high when req has at least one set bit (combinational).
second_valid  output  1  high when req has at least two set bits (combinational).
first_q  output  W  registered first.
second_q  output  W  registered second.
first_valid_q  output  1  registered first_valid.
second_valid_q  output  1  registered second_valid.

Behaviour:
- Combinational path: first, second, first_valid and second_valid are pure functions of req.
  - They are independent of clk and rst.
  - They settle within the same delta/timestep as a req change (zero cycles of latency).
- first: the largest i with req[i]=1. If req==0, first=0 and first_valid=0.
- second: the largest j < first with req[j]=1. If fewer than two bits are set, second=0 and second_valid=0.
- When both bits are set, first > second always holds. second never equals first when second_valid=1.
- Only the two highest set bits matter. All lower set bits are ignored.
- Implementation options:
  - Two cascaded priority scans: the second scan operates on req with bit[first] masked off.
  - Or one loop that tracks two indices.
  - Either must be fully parameterised in N.
- Non-power-of-two N: index codes >= N are never produced.
- Registered path: on each rising clk edge,
  - if rst=1, then first_q=0, second_q=0, first_valid_q=0, second_valid_q=0;
  - otherwise each *_q output captures its combinational counterpart.
  - Latency is one cycle.
- Reset:
  - Reset values are all zeros.
  - Reset affects only the *_q outputs. Asserting rst mid-operation clears them on the next edge, regardless of req.
  - The first edge after rst deasserts captures the current req result.
- No handshake and no internal state beyond the output registers.

Test Plan:
- Exhaustive sweep, N=12: apply req = 0..4095, each held about 2 ns (no clock dependence) -> first/second/valids match a reference model for every value.
- req=12'h000 -> first=0, second=0, first_valid=0, second_valid=0.
- req=12'h001 -> first=0, first_valid=1, second=0, second_valid=0. req=12'h800 -> first=11, first_valid=1, second_valid=0.
- Two-bit cases:
  - req=12'h801 -> first=11, second=0, both valids 1.
  - req=12'h0C0 -> first=7, second=6.
  - req=12'hFFF -> first=11, second=10.
- Registered path:
  - Hold rst=1 for 2 cycles with req=12'h0C0 -> all *_q = 0.
  - Deassert rst -> after the next rising edge, first_q=7, second_q=6, both *_valid_q=1.
  - Change req to 12'h024 -> *_q still 7/6 until the following edge, then 5/2.
- Reset mid-operation: with *_q holding 11/10, assert rst for one edge -> all *_q = 0 on that edge while the combinational outputs still show 11/10.
